// File: rtl/guess_evaluate_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// guess_evaluate_sequencer_pkg
//   Constants and types shared by the guess evaluation sequencer and its users.
//   - PIN_COLOR_W / PIN_POS_W : colour code width and pin index/count width
//   - max_pins_count          : pins per guess row
//   - max_guesses             : guess rows on the board
//   - ram_hints_offset        : first board RAM word holding packed hints; the
//                               pin area (max_pins_count * max_guesses words)
//                               ends just below it
//   - seq_state_e             : evaluation sequencer states
// -----------------------------------------------------------------------------
package guess_evaluate_sequencer_pkg;

    localparam int PIN_COLOR_W      = 5;
    localparam int PIN_POS_W        = 5;
    localparam int max_pins_count   = 20;
    localparam int max_guesses      = 99;
    localparam int ram_hints_offset = max_pins_count * max_guesses;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_HINTS  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage : guess_evaluate_sequencer_pkg

// File: rtl/guess_evaluate_sequencer.sv
// -----------------------------------------------------------------------------
// guess_evaluate_sequencer
//   Scores one entered guess against the secret (greens first, then yellows,
//   one comparison per clock) and commits the guess pins plus the packed
//   {green, yellow} hint word to the board RAM write port.
//
// Ports
//   clk          system clock
//   nreset       synchronous active-low reset
//   start        one-cycle request to evaluate and commit a guess
//   pins_count   active pins n (clamped to MAX_PINS)
//   guess_index  board row of this guess
//   guess        guess pins, pin i at [i*PIN_COLOR_W +: PIN_COLOR_W]
//   secret       secret pins, same packing
//   ram_we       board RAM write strobe
//   ram_addr     board RAM write address
//   ram_wdata    board RAM write data
//   busy         evaluation in progress
//   done         one-cycle pulse, score valid
//   err          one-cycle pulse, request rejected (row out of range)
//   green        exact matches, held until the next accepted start
//   yellow       colour-only matches, held until the next accepted start
//   win          green == n and n != 0, held with green
// -----------------------------------------------------------------------------
module guess_evaluate_sequencer #(
    parameter int PIN_COLOR_W  = guess_evaluate_sequencer_pkg::PIN_COLOR_W,
    parameter int PIN_POS_W    = guess_evaluate_sequencer_pkg::PIN_POS_W,
    parameter int MAX_PINS     = guess_evaluate_sequencer_pkg::max_pins_count,
    parameter int MAX_GUESSES  = guess_evaluate_sequencer_pkg::max_guesses,
    parameter int ADDR_W       = 12,
    parameter int HINTS_OFFSET = guess_evaluate_sequencer_pkg::ram_hints_offset
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic                            start,
    input  logic [PIN_POS_W-1:0]            pins_count,
    input  logic [7:0]                      guess_index,
    input  logic [MAX_PINS*PIN_COLOR_W-1:0] guess,
    input  logic [MAX_PINS*PIN_COLOR_W-1:0] secret,
    output logic                            ram_we,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [2*PIN_POS_W-1:0]          ram_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [PIN_POS_W-1:0]            green,
    output logic [PIN_POS_W-1:0]            yellow,
    output logic                            win
);

    // Only the state type and its literals come from the package; the width
    // constants are re-bound as parameters above.
    import guess_evaluate_sequencer_pkg::seq_state_e;
    import guess_evaluate_sequencer_pkg::ST_IDLE;
    import guess_evaluate_sequencer_pkg::ST_GREEN;
    import guess_evaluate_sequencer_pkg::ST_YELLOW;
    import guess_evaluate_sequencer_pkg::ST_HINTS;
    import guess_evaluate_sequencer_pkg::ST_DONE;

    localparam int DATA_W = 2 * PIN_POS_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e                  state_q;
    logic [PIN_POS_W-1:0]        n_q;          // clamped active pin count
    logic [7:0]                  idx_q;        // latched board row
    logic [PIN_COLOR_W-1:0]      guess_q  [MAX_PINS];
    logic [PIN_COLOR_W-1:0]      secret_q [MAX_PINS];
    logic [MAX_PINS-1:0]         mg_q;         // guess pin already scored
    logic [MAX_PINS-1:0]         ms_q;         // secret pin already consumed
    logic [PIN_POS_W-1:0]        i_q;          // guess pin under test
    logic [PIN_POS_W-1:0]        j_q;          // secret pin under test (yellow)
    logic [PIN_POS_W-1:0]        green_q;
    logic [PIN_POS_W-1:0]        yellow_q;
    logic                        win_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;
    logic                        ram_we_q;
    logic [ADDR_W-1:0]           ram_addr_q;
    logic [DATA_W-1:0]           ram_wdata_q;

    // ------------------------------------------------------------------
    // Next-state helpers shared by the scoring loop and the write mux
    // ------------------------------------------------------------------
    logic [PIN_POS_W-1:0]   n_clamped_d;
    logic [PIN_POS_W-1:0]   n_last_d;
    logic [PIN_POS_W-1:0]   i_next_d;
    logic [PIN_COLOR_W-1:0] guess_pin_i;
    logic [PIN_COLOR_W-1:0] secret_pin_i;
    logic [PIN_COLOR_W-1:0] secret_pin_j;
    logic                   row_invalid_d;
    logic                   yellow_hit_d;
    logic                   advance_i_d;
    logic [ADDR_W-1:0]      pin_addr_d;
    logic [ADDR_W-1:0]      hint_addr_d;

    assign n_clamped_d   = (pins_count > PIN_POS_W'(MAX_PINS)) ? PIN_POS_W'(MAX_PINS)
                                                               : pins_count;
    assign row_invalid_d = int'(guess_index) >= MAX_GUESSES;

    assign n_last_d     = n_q - 1'b1;
    assign i_next_d     = i_q + 1'b1;
    assign guess_pin_i  = guess_q[i_q];
    assign secret_pin_i = secret_q[i_q];
    assign secret_pin_j = secret_q[j_q];

    // A yellow needs an unconsumed secret pin of the same colour; the guess
    // side is qualified separately because an already-green guess pin skips
    // the search entirely.
    assign yellow_hit_d = !ms_q[j_q] && (guess_pin_i == secret_pin_j);

    // The yellow search for guess pin i ends when it was already green, when
    // it found a partner, or when the last secret pin has been tried.
    assign advance_i_d  = mg_q[i_q] || yellow_hit_d || (j_q == n_last_d);

    // Widened before multiplying so the row product cannot wrap.
    assign pin_addr_d   = ADDR_W'(idx_q) * ADDR_W'(MAX_PINS) + ADDR_W'(i_q);
    assign hint_addr_d  = ADDR_W'(HINTS_OFFSET) + ADDR_W'(idx_q);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            // NOTE: the pin stores and RAM address/data registers are reset
            // as well, so ram_addr/ram_wdata never carry X even while idle.
            state_q     <= ST_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            for (int k = 0; k < MAX_PINS; k++) begin
                guess_q[k]  <= '0;
                secret_q[k] <= '0;
            end
            mg_q        <= '0;
            ms_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            green_q     <= '0;
            yellow_q    <= '0;
            win_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            // NOTE: every register here uses <= so all decisions in one
            // cycle see the same pre-edge values (e.g. mg_q/ms_q while
            // green_q is being incremented).
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ram_we_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (row_invalid_d) begin
                            err_q <= 1'b1;
                        end else begin
                            n_q   <= n_clamped_d;
                            idx_q <= guess_index;
                            for (int k = 0; k < MAX_PINS; k++) begin
                                guess_q[k]  <= guess[k*PIN_COLOR_W +: PIN_COLOR_W];
                                secret_q[k] <= secret[k*PIN_COLOR_W +: PIN_COLOR_W];
                            end
                            mg_q     <= '0;
                            ms_q     <= '0;
                            i_q      <= '0;
                            j_q      <= '0;
                            green_q  <= '0;
                            yellow_q <= '0;
                            win_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            // An empty guess has nothing to score; only the
                            // zero hint word gets written.
                            state_q  <= (n_clamped_d == '0) ? ST_HINTS : ST_GREEN;
                        end
                    end
                end

                ST_GREEN: begin
                    ram_we_q    <= 1'b1;
                    ram_addr_q  <= pin_addr_d;
                    ram_wdata_q <= DATA_W'(guess_pin_i);
                    if (guess_pin_i == secret_pin_i) begin
                        mg_q[i_q] <= 1'b1;
                        ms_q[i_q] <= 1'b1;
                        green_q   <= green_q + 1'b1;
                    end
                    if (i_q == n_last_d) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= ST_YELLOW;
                    end else begin
                        i_q <= i_next_d;
                    end
                end

                ST_YELLOW: begin
                    if (!mg_q[i_q] && yellow_hit_d) begin
                        mg_q[i_q] <= 1'b1;
                        ms_q[j_q] <= 1'b1;
                        yellow_q  <= yellow_q + 1'b1;
                    end
                    if (advance_i_d) begin
                        i_q <= i_next_d;
                        j_q <= '0;
                        if (i_next_d == n_q) begin
                            state_q <= ST_HINTS;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end

                ST_HINTS: begin
                    ram_we_q    <= 1'b1;
                    ram_addr_q  <= hint_addr_d;
                    ram_wdata_q <= {green_q, yellow_q};
                    state_q     <= ST_DONE;
                end

                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    win_q   <= (green_q == n_q) && (n_q != '0);
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs are driven straight from registers
    // ------------------------------------------------------------------
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign green     = green_q;
    assign yellow    = yellow_q;
    assign win       = win_q;

endmodule : guess_evaluate_sequencer

// File: tb/tb_guess_evaluate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_guess_evaluate_sequencer
//   Table of guess/secret records with hand-derived scores, applied in a loop.
//   Expected RAM writes are queued when a request is driven and popped by a
//   monitor as the writes appear. Hand-written sequences cover rejection,
//   start-while-busy and reset during the yellow phase.
// -----------------------------------------------------------------------------
module tb_guess_evaluate_sequencer;
    import guess_evaluate_sequencer_pkg::*;

    localparam int MP  = 20;                 // pins per row
    localparam int HO  = 1980;               // hint word base address
    localparam int PW  = MP * PIN_COLOR_W;   // packed pin vector width

    typedef struct {
        int              n;
        int              idx;
        logic [PW-1:0]   guess;
        logic [PW-1:0]   secret;
        int              exp_green;
        int              exp_yellow;
        bit              exp_win;
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [9:0]  data;
    } wr_t;

    logic                   clk;
    logic                   nreset;
    logic                   start;
    logic [PIN_POS_W-1:0]   pins_count;
    logic [7:0]             guess_index;
    logic [PW-1:0]          guess;
    logic [PW-1:0]          secret;
    logic                   ram_we;
    logic [11:0]            ram_addr;
    logic [2*PIN_POS_W-1:0] ram_wdata;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [PIN_POS_W-1:0]   green;
    logic [PIN_POS_W-1:0]   yellow;
    logic                   win;

    int  n_checks   = 0;
    int  n_fail     = 0;
    int  done_count = 0;
    wr_t exp_q[$];
    vec_t vecs[8];

    guess_evaluate_sequencer dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .pins_count  (pins_count),
        .guess_index (guess_index),
        .guess       (guess),
        .secret      (secret),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .green       (green),
        .yellow      (yellow),
        .win         (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(ram_we), 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(w.addr));
                check("wr_data", 32'(ram_wdata), 32'(w.data));
            end
        end
    end

    function automatic logic [PW-1:0] pk6(input int p0, input int p1, input int p2,
                                         input int p3, input int p4, input int p5);
        logic [PW-1:0] r;
        r = '0;
        r[0*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p0);
        r[1*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p1);
        r[2*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p2);
        r[3*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p3);
        r[4*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p4);
        r[5*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(p5);
        return r;
    endfunction

    function automatic int pin(input logic [PW-1:0] v, input int k);
        return int'(v[k*PIN_COLOR_W +: PIN_COLOR_W]);
    endfunction

    function automatic int clamp_n(input int n);
        return (n > MP) ? MP : n;
    endfunction

    // Number of yellow-phase cycles for a request, following the stepping
    // rule: skip scored pins, match against unconsumed secret pins, give up
    // after the last secret pin.
    function automatic int yellow_steps(input vec_t v);
        bit mg[MP];
        bit ms[MP];
        int n, i, j, steps;
        n = clamp_n(v.n);
        for (int k = 0; k < MP; k++) begin
            mg[k] = (k < n) && (pin(v.guess, k) == pin(v.secret, k));
            ms[k] = mg[k];
        end
        i = 0; j = 0; steps = 0;
        while (i < n) begin
            steps++;
            if (mg[i]) begin
                i++; j = 0;
            end else if (!ms[j] && pin(v.guess, i) == pin(v.secret, j)) begin
                mg[i] = 1; ms[j] = 1; i++; j = 0;
            end else if (j == n - 1) begin
                i++; j = 0;
            end else begin
                j++;
            end
        end
        return steps;
    endfunction

    task automatic push_pin_writes(input vec_t v);
        for (int k = 0; k < clamp_n(v.n); k++)
            exp_q.push_back('{addr: 12'(v.idx * MP + k), data: 10'(pin(v.guess, k))});
    endtask

    task automatic drive_start(input vec_t v);
        pins_count  = PIN_POS_W'(v.n);
        guess_index = 8'(v.idx);
        guess       = v.guess;
        secret      = v.secret;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Full request: queued writes, latency, held score, single done pulse.
    task automatic run_vec(input vec_t v, input bit disturb);
        int  nn, k, d0;
        bit  got;
        nn = clamp_n(v.n);
        push_pin_writes(v);
        exp_q.push_back('{addr: 12'(HO + v.idx),
                          data: 10'((v.exp_green << PIN_POS_W) | v.exp_yellow)});
        d0 = done_count;
        drive_start(v);
        check("busy_after_start", 32'(busy), 32'd1);
        check("green_cleared", 32'(green), 32'd0);
        check("win_cleared", 32'(win), 32'd0);
        k = 0; got = 0;
        while (!got && k < 600) begin
            if (disturb && k == 2) begin
                // A second request mid-run must be ignored entirely.
                start       = 1'b1;
                guess_index = 8'd0;
                pins_count  = PIN_POS_W'(1);
                guess       = ~v.guess;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (done === 1'b1) got = 1;
        end
        if (!got) begin
            check("done_timeout", 32'(got), 32'd1);
        end else begin
            // Edges after the sampling edge: n green, yellow steps, hints, done.
            check("latency", 32'(k), 32'(nn + yellow_steps(v) + 2));
            check("green", 32'(green), 32'(v.exp_green));
            check("yellow", 32'(yellow), 32'(v.exp_yellow));
            check("win", 32'(win), 32'(v.exp_win));
            check("busy_at_done", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        check("done_single_cycle", 32'(done), 32'd0);
        check("score_held", 32'(green), 32'(v.exp_green));
        repeat (2) begin @(posedge clk); #1; end
        check("done_count", 32'(done_count - d0), 32'd1);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Table: hand-scored requests.
        vecs[0] = '{4, 0, pk6(0,1,2,3,0,0), pk6(0,1,2,3,0,0), 4, 0, 1};
        vecs[1] = '{4, 1, pk6(1,0,3,2,0,0), pk6(0,1,2,3,0,0), 0, 4, 0};
        vecs[2] = '{4, 2, pk6(0,1,0,5,0,0), pk6(0,0,1,1,0,0), 1, 2, 0};
        vecs[3] = '{0, 5, pk6(7,7,7,7,7,7), pk6(7,7,7,7,7,7), 0, 0, 0};
        vecs[4] = '{25, 10, '0, '0, 20, 0, 1};
        vecs[5] = '{20, 98, '0, '0, 0, 20, 0};
        vecs[6] = '{6, 7, pk6(3,7,3,3,9,4), pk6(3,3,7,1,2,9), 1, 3, 0};
        vecs[7] = '{3, 3, pk6(1,2,3,9,0,0), pk6(1,2,3,4,0,0), 3, 0, 1};
        for (int k = 0; k < MP; k++) begin
            vecs[4].guess [k*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(k + 1);
            vecs[4].secret[k*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(k + 1);
            vecs[5].secret[k*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'(k);
            vecs[5].guess [k*PIN_COLOR_W +: PIN_COLOR_W] = PIN_COLOR_W'((k + 1) % MP);
        end

        nreset      = 1'b0;
        start       = 1'b0;
        pins_count  = '0;
        guess_index = '0;
        guess       = '0;
        secret      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_green", 32'(green), 32'd0);
        check("rst_yellow", 32'(yellow), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        nreset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        for (int v = 0; v < 8; v++)
            run_vec(vecs[v], v == 2);

        // Out-of-range row: err pulse only, no writes, never busy.
        begin
            vec_t r;
            int   d0;
            r   = vecs[0];
            r.idx = 99;
            d0  = done_count;
            drive_start(r);
            check("reject_err", 32'(err), 32'd1);
            check("reject_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            check("reject_err_pulse", 32'(err), 32'd0);
            repeat (4) begin @(posedge clk); #1; end
            check("reject_busy_later", 32'(busy), 32'd0);
            check("reject_no_done", 32'(done_count - d0), 32'd0);
        end

        // Reset while scoring yellows: pin writes only, then silence.
        begin
            int d0, nn;
            nn = clamp_n(vecs[6].n);
            push_pin_writes(vecs[6]);
            d0 = done_count;
            drive_start(vecs[6]);
            repeat (nn + 1) begin @(posedge clk); #1; end
            check("busy_before_reset", 32'(busy), 32'd1);
            check("green_before_reset", 32'(green), 32'd1);
            nreset = 1'b0;
            @(posedge clk); #1;
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_ram_we", 32'(ram_we), 32'd0);
            check("mid_rst_green", 32'(green), 32'd0);
            check("mid_rst_yellow", 32'(yellow), 32'd0);
            check("mid_rst_win", 32'(win), 32'd0);
            check("mid_rst_done", 32'(done), 32'd0);
            nreset = 1'b1;
            repeat (6) begin @(posedge clk); #1; end
            check("mid_rst_idle", 32'(busy), 32'd0);
            check("mid_rst_no_done", 32'(done_count - d0), 32'd0);
            check("mid_rst_writes", 32'(exp_q.size()), 32'd0);
        end

        run_vec(vecs[6], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_guess_evaluate_sequencer
